// File: rtl/line_rasterizer.sv
// Bresenham segment rasterizer: captures one endpoint pair and a color, then streams
// the segment's pixels (off-screen ones clipped) to the framebuffer writer.
module line_rasterizer #(
    parameter int XRES = 640,
    parameter int YRES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [37:0] locations,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_color
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t state, state_nxt;

    logic [37:0]        loc_q;
    logic [15:0]        color_q;
    logic [9:0]         x;
    logic [8:0]         y;
    logic signed [12:0] dx, dy, err;
    logic               sx_neg, sy_neg;

    logic [9:0]         x0, x1, dx_abs;
    logic [8:0]         y0, y1, dy_abs;
    logic               on_screen, at_end, advance, step_x, step_y;
    logic signed [12:0] e2, err_nxt;

    assign x0 = loc_q[37:28];
    assign y0 = loc_q[27:19];
    assign x1 = loc_q[18:9];
    assign y1 = loc_q[8:0];

    assign dx_abs = (x1 > x0) ? (x1 - x0) : (x0 - x1);
    assign dy_abs = (y1 > y0) ? (y1 - y0) : (y0 - y1);

    assign on_screen = ({22'd0, x} < 32'(XRES)) && ({23'd0, y} < 32'(YRES));
    assign at_end    = (x == x1) && (y == y1);

    // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready.
    // pix_valid is decoded from registered state only and, once high, it and the
    // pixel fields hold until that transfer. Clipped pixels advance without a handshake.
    assign advance = (state == DRAW) && (!on_screen || pix_ready);

    assign e2      = err <<< 1;
    assign step_x  = (e2 >= dy);
    assign step_y  = (e2 <= dx);
    assign err_nxt = err + (step_x ? dy : 13'sd0) + (step_y ? dx : 13'sd0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   state_nxt = DRAW;
            DRAW:    if (advance && at_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loc_q   <= '0;
            color_q <= '0;
            x       <= '0;
            y       <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                loc_q   <= locations;
                color_q <= color;
            end
            if (state == SETUP) begin
                x      <= x0;
                y      <= y0;
                dx     <= $signed({3'b000, dx_abs});
                dy     <= -$signed({4'b0000, dy_abs});
                err    <= $signed({3'b000, dx_abs}) - $signed({4'b0000, dy_abs});
                sx_neg <= !(x0 < x1);
                sy_neg <= !(y0 < y1);
            end
            if (advance && !at_end) begin
                err <= err_nxt;
                if (step_x) x <= x + (sx_neg ? 10'h3FF : 10'd1);
                if (step_y) y <= y + (sy_neg ? 9'h1FF : 9'd1);
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign pix_valid = (state == DRAW) && on_screen;
    assign pix_x     = x;
    assign pix_y     = y;
    assign pix_color = color_q;

endmodule
